uno_card_renderer: RTL and testbench

//  Pixel source directly upstream of the vga output stage: for each pixel coordinate from the VGA timing

---
 rtl/uno_pkg.sv | 55 +++++
 rtl/uno_seg7_mask.sv | 68 ++++++
 rtl/uno_card_renderer.sv | 158 +++++++++++++++
 tb/tb_uno_card_renderer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uno_pkg.sv
// Shared types and constants for the UNO table renderer: card descriptor,
// colour palette and the card/glyph geometry.
package uno_pkg;

  localparam int NUM_SLOTS_DEF = 8;
  localparam int CARD_W_DEF    = 64;
  localparam int CARD_H_DEF    = 96;
  localparam int BORDER_DEF    = 2;

  // White centre panel inset from the card edges
  localparam int CENTRE_MX = 12;
  localparam int CENTRE_MY = 16;

  // 7-segment glyph box, relative to the card origin
  localparam int GLYPH_X0 = 20;
  localparam int GLYPH_Y0 = 28;
  localparam int GLYPH_W  = 24;
  localparam int GLYPH_H  = 40;
  localparam int SEG_T    = 4;
  localparam int SEG_G0   = GLYPH_H / 2 - SEG_T / 2;

  typedef enum logic [1:0] {RED, YELLOW, GREEN, BLUE} uno_color_e;

  typedef struct packed {
    logic       en;
    uno_color_e color;
    logic [3:0] value;
    logic [9:0] px;
    logic [8:0] py;
  } card_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t RGB_BG     = '{r: 8'h00, g: 8'h60, b: 8'h20};
  localparam rgb_t RGB_BLACK  = '{r: 8'h00, g: 8'h00, b: 8'h00};
  localparam rgb_t RGB_WHITE  = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
  localparam rgb_t RGB_RED    = '{r: 8'hE0, g: 8'h20, b: 8'h20};
  localparam rgb_t RGB_YELLOW = '{r: 8'hF0, g: 8'hD0, b: 8'h00};
  localparam rgb_t RGB_GREEN  = '{r: 8'h20, g: 8'hA0, b: 8'h40};
  localparam rgb_t RGB_BLUE   = '{r: 8'h20, g: 8'h40, b: 8'hE0};

  function automatic rgb_t palette(input uno_color_e c);
    case (c)
      RED:     return RGB_RED;
      YELLOW:  return RGB_YELLOW;
      GREEN:   return RGB_GREEN;
      default: return RGB_BLUE;
    endcase
  endfunction

endpackage

// File: rtl/uno_seg7_mask.sv
// Combinational 7-segment glyph mask: is card-local pixel (dx,dy) part of
// the digit drawn for value? Values above 9 draw nothing.
module uno_seg7_mask
  import uno_pkg::*;
#(
  parameter int DXW = 6,
  parameter int DYW = 7
) (
  input  logic [DXW-1:0] dx,
  input  logic [DYW-1:0] dy,
  input  logic [3:0]     value,
  output logic           pix
);

  localparam logic [DXW-1:0] X0   = DXW'(GLYPH_X0);
  localparam logic [DXW-1:0] X1   = DXW'(GLYPH_X0 + GLYPH_W);
  localparam logic [DYW-1:0] Y0   = DYW'(GLYPH_Y0);
  localparam logic [DYW-1:0] Y1   = DYW'(GLYPH_Y0 + GLYPH_H);
  localparam logic [DXW-1:0] T_X  = DXW'(SEG_T);
  localparam logic [DXW-1:0] R_X  = DXW'(GLYPH_W - SEG_T);
  localparam logic [DYW-1:0] T_Y  = DYW'(SEG_T);
  localparam logic [DYW-1:0] G0   = DYW'(SEG_G0);
  localparam logic [DYW-1:0] G1   = DYW'(SEG_G0 + SEG_T);
  localparam logic [DYW-1:0] D_Y  = DYW'(GLYPH_H - SEG_T);

  logic [6:0]     seg;  // {a,b,c,d,e,f,g}
  logic [DXW-1:0] bx;
  logic [DYW-1:0] by;
  logic           in_box, h_a, h_g, h_d, v_l, v_r, up, lo;

  always_comb begin
    case (value)
      4'd0:    seg = 7'b1111110;
      4'd1:    seg = 7'b0110000;
      4'd2:    seg = 7'b1101101;
      4'd3:    seg = 7'b1111001;
      4'd4:    seg = 7'b0110011;
      4'd5:    seg = 7'b1011011;
      4'd6:    seg = 7'b1011111;
      4'd7:    seg = 7'b1110000;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1111011;
      default: seg = 7'b0000000;
    endcase
  end

  assign in_box = (dx >= X0) && (dx < X1) && (dy >= Y0) && (dy < Y1);
  assign bx     = DXW'(dx - X0);
  assign by     = DYW'(dy - Y0);

  assign h_a = by < T_Y;
  assign h_g = (by >= G0) && (by < G1);
  assign h_d = by >= D_Y;
  assign v_l = bx < T_X;
  assign v_r = bx >= R_X;
  // upper verticals run down through the middle bar, lower ones up into it
  assign up  = by < G1;
  assign lo  = by >= G0;

  assign pix = in_box && ((seg[6] && h_a)       ||
                          (seg[5] && v_r && up) ||
                          (seg[4] && v_r && lo) ||
                          (seg[3] && h_d)       ||
                          (seg[2] && v_l && lo) ||
                          (seg[1] && v_l && up) ||
                          (seg[0] && h_g));

endmodule

// File: rtl/uno_card_renderer.sv
// UNO table pixel source: shadow/live card descriptors committed per frame,
// 2-stage hit-test / colour pipeline producing RGB aligned with o_de.
module uno_card_renderer
  import uno_pkg::*;
#(
  parameter int NUM_SLOTS = NUM_SLOTS_DEF,
  parameter int CARD_W    = CARD_W_DEF,
  parameter int CARD_H    = CARD_H_DEF,
  parameter int BORDER    = BORDER_DEF
) (
  input  logic                         i_clk_25M,
  input  logic                         i_rst_n,
  input  logic [9:0]                   i_x,
  input  logic [9:0]                   i_y,
  input  logic                         i_de,
  input  logic                         i_frame_start,
  input  logic                         i_wr_valid,
  output logic                         o_wr_ready,
  input  logic [$clog2(NUM_SLOTS)-1:0] i_wr_slot,
  input  card_t                        i_wr_card,
  output logic [7:0]                   o_r,
  output logic [7:0]                   o_g,
  output logic [7:0]                   o_b,
  output logic                         o_de
);

  localparam int SW  = $clog2(NUM_SLOTS);
  localparam int DXW = $clog2(CARD_W);
  localparam int DYW = $clog2(CARD_H);

  localparam logic [DXW-1:0] BX_LO = DXW'(BORDER);
  localparam logic [DXW-1:0] BX_HI = DXW'(CARD_W - BORDER);
  localparam logic [DYW-1:0] BY_LO = DYW'(BORDER);
  localparam logic [DYW-1:0] BY_HI = DYW'(CARD_H - BORDER);
  localparam logic [DXW-1:0] CX_LO = DXW'(CENTRE_MX);
  localparam logic [DXW-1:0] CX_HI = DXW'(CARD_W - CENTRE_MX);
  localparam logic [DYW-1:0] CY_LO = DYW'(CENTRE_MY);
  localparam logic [DYW-1:0] CY_HI = DYW'(CARD_H - CENTRE_MY);

  card_t shadow_q [NUM_SLOTS];
  card_t live_q   [NUM_SLOTS];
  logic  wr_fire;

  // writes are refused only in the commit cycle, so commit never races a write
  assign o_wr_ready = ~i_frame_start;
  assign wr_fire    = i_wr_valid & o_wr_ready;

  logic [NUM_SLOTS-1:0] hit;

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    logic [10:0] x_end, y_end;

    always_ff @(posedge i_clk_25M or negedge i_rst_n) begin
      if (!i_rst_n) begin
        shadow_q[s] <= '0;
        live_q[s]   <= '0;
      end else begin
        if (wr_fire && i_wr_slot == SW'(s)) shadow_q[s] <= i_wr_card;
        if (i_frame_start)                  live_q[s]   <= shadow_q[s];
      end
    end

    // 11-bit ends so cards near the right/bottom clip instead of wrapping
    assign x_end  = {1'b0, live_q[s].px} + 11'(CARD_W);
    assign y_end  = {2'b0, live_q[s].py} + 11'(CARD_H);
    assign hit[s] = live_q[s].en &&
                    (i_x >= live_q[s].px) && ({1'b0, i_x} < x_end) &&
                    (i_y >= {1'b0, live_q[s].py}) && ({1'b0, i_y} < y_end);
  end

  // Stage 1: highest-index hit wins
  logic       win_hit;
  uno_color_e win_color;
  logic [3:0] win_value;
  logic [9:0] win_px;
  logic [8:0] win_py;

  always_comb begin
    win_hit   = 1'b0;
    win_color = RED;
    win_value = '0;
    win_px    = '0;
    win_py    = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (hit[s]) begin
        win_hit   = 1'b1;
        win_color = live_q[s].color;
        win_value = live_q[s].value;
        win_px    = live_q[s].px;
        win_py    = live_q[s].py;
      end
    end
  end

  logic           s1_hit_q;
  uno_color_e     s1_color_q;
  logic [3:0]     s1_value_q;
  logic [DXW-1:0] s1_dx_q, s1_dx_d;
  logic [DYW-1:0] s1_dy_q, s1_dy_d;
  logic [1:0]     de_pipe_q;

  assign s1_dx_d = DXW'(i_x - win_px);
  assign s1_dy_d = DYW'(i_y - {1'b0, win_py});

  always_ff @(posedge i_clk_25M or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_hit_q   <= 1'b0;
      s1_color_q <= RED;
      s1_value_q <= '0;
      s1_dx_q    <= '0;
      s1_dy_q    <= '0;
      de_pipe_q  <= '0;
    end else begin
      s1_hit_q   <= win_hit;
      s1_color_q <= win_color;
      s1_value_q <= win_value;
      s1_dx_q    <= s1_dx_d;
      s1_dy_q    <= s1_dy_d;
      de_pipe_q  <= {de_pipe_q[0], i_de};
    end
  end

  // Stage 2: colour select
  logic glyph, border, centre;
  rgb_t rgb_d, rgb_q;

  uno_seg7_mask #(.DXW(DXW), .DYW(DYW)) u_seg7 (
    .dx    (s1_dx_q),
    .dy    (s1_dy_q),
    .value (s1_value_q),
    .pix   (glyph)
  );

  assign border = (s1_dx_q < BX_LO) || (s1_dx_q >= BX_HI) ||
                  (s1_dy_q < BY_LO) || (s1_dy_q >= BY_HI);
  assign centre = (s1_dx_q >= CX_LO) && (s1_dx_q < CX_HI) &&
                  (s1_dy_q >= CY_LO) && (s1_dy_q < CY_HI);

  always_comb begin
    rgb_d = RGB_BLACK;
    if (!de_pipe_q[0])  rgb_d = RGB_BLACK;
    else if (!s1_hit_q) rgb_d = RGB_BG;
    else if (border)    rgb_d = RGB_BLACK;
    else if (centre)    rgb_d = glyph ? RGB_BLACK : RGB_WHITE;
    else                rgb_d = palette(s1_color_q);
  end

  always_ff @(posedge i_clk_25M or negedge i_rst_n) begin
    if (!i_rst_n) rgb_q <= '0;
    else          rgb_q <= rgb_d;
  end

  assign o_r  = rgb_q.r;
  assign o_g  = rgb_q.g;
  assign o_b  = rgb_q.b;
  assign o_de = de_pipe_q[1];

endmodule

// File: tb/tb_uno_card_renderer.sv
// Randomised bench for uno_card_renderer against a pixel-rule reference model.
module tb_uno_card_renderer;
  import uno_pkg::*;

  localparam int NS = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] x = '0, y = '0;
  logic       de = 1'b0, fs = 1'b0, wv = 1'b0;
  logic [2:0] ws = '0;
  card_t      wc = '0;
  logic       ready, ode;
  logic [7:0] r, g, b;

  always #20 clk = ~clk;

  uno_card_renderer dut (
    .i_clk_25M     (clk),
    .i_rst_n       (rst_n),
    .i_x           (x),
    .i_y           (y),
    .i_de          (de),
    .i_frame_start (fs),
    .i_wr_valid    (wv),
    .o_wr_ready    (ready),
    .i_wr_slot     (ws),
    .i_wr_card     (wc),
    .o_r           (r),
    .o_g           (g),
    .o_b           (b),
    .o_de          (ode)
  );

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  // reference state: what game logic has written, and what is on screen
  card_t sh [NS];
  card_t lv [NS];

  typedef struct {
    logic [24:0] v;
    int          px;
    int          py;
  } exp_t;
  exp_t q[$];

  function automatic logic [24:0] ref_pix(input int px, input int py, input bit d);
    int masks[10] = '{'h7E, 'h30, 'h6D, 'h79, 'h33, 'h5B, 'h5F, 'h70, 'h7F, 'h7B};
    int pal[4]    = '{'hE02020, 'hF0D000, 'h20A040, 'h2040E0};
    // segments a..g as box rectangles [x0,x1] x [y0,y1]
    int sx0[7] = '{0, 20, 20, 0, 0, 0, 0};
    int sx1[7] = '{23, 23, 23, 23, 3, 3, 23};
    int sy0[7] = '{0, 0, 18, 36, 18, 0, 18};
    int sy1[7] = '{3, 21, 39, 39, 39, 21, 21};
    int win = -1;
    int dx, dy, cx, cy, val;
    bit on = 0;
    if (!d) return 25'h0;
    for (int s = NS - 1; s >= 0; s--) begin
      int cpx = int'(lv[s].px);
      int cpy = int'(lv[s].py);
      if (win < 0 && lv[s].en && px >= cpx && px < cpx + 64 && py >= cpy && py < cpy + 96)
        win = s;
    end
    if (win < 0) return {1'b1, 24'h006020};
    dx = px - int'(lv[win].px);
    dy = py - int'(lv[win].py);
    if (dx < 2 || dx >= 62 || dy < 2 || dy >= 94) return {1'b1, 24'h000000};
    if (dx >= 12 && dx < 52 && dy >= 16 && dy < 80) begin
      val = int'(lv[win].value);
      cx = dx - 20;
      cy = dy - 28;
      if (val <= 9)
        for (int k = 0; k < 7; k++)
          if (masks[val][6-k] && cx >= sx0[k] && cx <= sx1[k] && cy >= sy0[k] && cy <= sy1[k])
            on = 1;
      return on ? {1'b1, 24'h000000} : {1'b1, 24'hFFFFFF};
    end
    return {1'b1, pal[int'(lv[win].color)][23:0]};
  endfunction

  // one clock: predict for current inputs, advance the model, check output of the previous step
  task automatic step();
    exp_t e;
    e.v  = ref_pix(int'(x), int'(y), de);
    e.px = int'(x);
    e.py = int'(y);
    q.push_back(e);
    @(posedge clk);
    if (fs) for (int s = 0; s < NS; s++) lv[s] = sh[s];
    else if (wv) sh[ws] = wc;
    #1;
    if (q.size() == 2) begin
      e = q.pop_front();
      chk($sformatf("pix(%0d,%0d)", e.px, e.py), {7'b0, ode, r, g, b}, {7'b0, e.v});
    end
  endtask

  task automatic pix(input int px, input int py, input bit d = 1'b1);
    x  = 10'(px);
    y  = 10'(py);
    de = d;
    step();
  endtask

  task automatic wr(input int slot, input bit en, input int col, input int val,
                    input int px, input int py);
    wv = 1'b1;
    ws = 3'(slot);
    wc = '{en: en, color: uno_color_e'(col), value: 4'(val), px: 10'(px), py: 9'(py)};
    de = 1'b0;
    step();
    wv = 1'b0;
  endtask

  task automatic commit();
    fs = 1'b1;
    de = 1'b0;
    step();
    fs = 1'b0;
  endtask

  task automatic model_clear();
    for (int s = 0; s < NS; s++) begin
      sh[s] = '0;
      lv[s] = '0;
    end
    q.delete();
  endtask

  initial begin
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", {7'b0, ode, r, g, b}, 32'h0);
    chk("rst_ready", {31'b0, ready}, 32'h1);
    rst_n = 1'b1;

    // 1: empty table, sampled rows of a frame
    for (int row = 0; row < 4; row++) begin
      int yy = (row == 3) ? 479 : row * 160;
      for (int xx = 0; xx < 640; xx += 7) pix(xx, yy);
    end
    pix(639, 479);
    pix(5, 5, 1'b0);
    chk("ready_idle", {31'b0, ready}, 32'h1);

    // 2: blue 7 at (100,50)
    wr(0, 1, 3, 7, 100, 50);
    commit();
    pix(100, 50);
    pix(110, 60);
    pix(120, 78);
    pix(135, 90);
    for (int i = 0; i < 80; i++) pix(100 + $urandom_range(0, 70), 50 + $urandom_range(0, 100));

    // 3: shadow write is invisible until the next commit
    wr(0, 1, 0, 2, 100, 50);
    pix(110, 60);
    pix(130, 98);
    commit();
    pix(110, 60);
    pix(130, 98);

    // 4: overlap, slot 5 on top, then disabled
    wr(0, 1, 2, 8, 180, 180);
    wr(5, 1, 1, 3, 190, 190);
    commit();
    pix(200, 200);
    pix(195, 195);
    wr(5, 0, 1, 3, 190, 190);
    commit();
    pix(200, 200);
    pix(195, 195);

    // 5: right/bottom edge clipping
    wr(3, 1, 1, 0, 600, 450);
    commit();
    for (int xx = 590; xx < 640; xx++) pix(xx, 460);
    for (int xx = 0; xx < 30; xx++) pix(xx, 460);
    pix(620, 479);
    pix(620, 0);

    // 6: write held across frame_start
    wv = 1'b1;
    ws = 3'd1;
    wc = '{en: 1'b1, color: GREEN, value: 4'd5, px: 10'd300, py: 9'd300};
    fs = 1'b1;
    x = 10'd310; y = 10'd310; de = 1'b1;
    #1;
    chk("ready_fs", {31'b0, ready}, 32'h0);
    step();
    fs = 1'b0;
    #1;
    chk("ready_after_fs", {31'b0, ready}, 32'h1);
    step();
    wv = 1'b0;
    pix(310, 310);
    commit();
    pix(310, 310);
    pix(330, 340);

    // mid-line reset
    pix(320, 320);
    pix(110, 60);
    rst_n = 1'b0;
    #1;
    chk("midrst_out", {7'b0, ode, r, g, b}, 32'h0);
    chk("midrst_ready", {31'b0, ready}, 32'h1);
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pix(310, 310);
    chk("post_rel1", {7'b0, ode, r, g, b}, 32'h0);
    commit();
    pix(310, 310);
    pix(610, 460);
    pix(110, 60);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      int sel = $urandom_range(0, 99);
      if (sel < 8) begin
        wr($urandom_range(0, NS - 1), $urandom_range(0, 4) != 0, $urandom_range(0, 3),
           $urandom_range(0, 15), $urandom_range(0, 660), $urandom_range(0, 500));
      end else if (sel < 10) begin
        commit();
      end else if (sel < 60) begin
        int s = $urandom_range(0, NS - 1);
        pix((int'(lv[s].px) + $urandom_range(0, 70)) % 1024,
            (int'(lv[s].py) + $urandom_range(0, 100)) % 1024, $urandom_range(0, 9) != 0);
      end else begin
        pix($urandom_range(0, 639), $urandom_range(0, 479), $urandom_range(0, 9) != 0);
      end
    end

    pix(0, 0, 1'b0);
    pix(0, 0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
